// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//
// Round-robin arbiter sharing the single write port of fifo1 among NREQ
// requesters. One requester owns the port at a time. The grant is held for
// one packet, or for at most BURST words, whichever ends first. After every
// grant there is one idle cycle, and the owner that just released moves to
// lowest priority.
//
// Parameters
//   NREQ  : number of requesters (>= 2)
//   DSIZE : data width, matches fifo1 DSIZE
//   BURST : maximum words transferred per grant (>= 1)
//
// Ports
//   wclk       in            write clock, rising edge
//   wrst_n     in            asynchronous active-low reset
//   req_valid  in  [NREQ]    requester i presents a word
//   req_data   in  [NREQ*DSIZE] requester i data at [i*DSIZE +: DSIZE]
//   req_last   in  [NREQ]    current word of requester i ends its packet
//   req_ready  out [NREQ]    word accepted from i when valid & ready
//   wfull      in            fifo1 full flag (already registered in fifo1)
//   winc       out           write strobe to fifo1, one word per high cycle
//   wdata      out [DSIZE]   write data to fifo1, zero while idle
//   gnt        out [NREQ]    registered one-hot owner, zero while idle
//   busy       out           high while a grant is held
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);

  localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [CW-1:0] BURST_W  = CW'(BURST);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [PW-1:0]   own_reg, own_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // -------------------------------------------------------------------------
  // Owner multiplexing. gnt_reg is zero in IDLE, so every masked term below
  // is zero there too; that is what forces wdata to 0 while idle.
  // -------------------------------------------------------------------------
  logic [DSIZE-1:0] data_masked [NREQ];
  logic [DSIZE-1:0] data_or;
  logic             own_valid;
  logic             own_last;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_data_mask
      assign data_masked[gi] = req_data[gi*DSIZE +: DSIZE] & {DSIZE{gnt_reg[gi]}};
    end
  endgenerate

  always_comb begin
    data_or = '0;
    for (int i = 0; i < NREQ; i++) begin
      data_or = data_or | data_masked[i];
    end
  end

  assign own_valid = |(req_valid & gnt_reg);
  assign own_last  = |(req_last  & gnt_reg);

  // -------------------------------------------------------------------------
  // Rotating priority search. Duplicating req_valid and shifting it right by
  // ptr puts requester ptr at bit 0. The lowest set bit in the low NREQ bits
  // is then the offset from ptr of the winner.
  // -------------------------------------------------------------------------
  logic [2*NREQ-1:0] dbl_valid;
  logic [PW-1:0]     sel_off;
  logic [PW:0]       sel_sum;
  logic [PW-1:0]     sel_idx;
  logic              sel_found;

  assign dbl_valid = {req_valid, req_valid} >> ptr_reg;

  always_comb begin
    sel_found = 1'b0;
    sel_off   = '0;
    // Scan downwards so that the lowest offset is the last one written.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (dbl_valid[k]) begin
        sel_found = 1'b1;
        sel_off   = PW'(k);
      end
    end
  end

  assign sel_sum = {1'b0, ptr_reg} + {1'b0, sel_off};
  assign sel_idx = (sel_sum >= NREQ_W) ? PW'(sel_sum - NREQ_W) : PW'(sel_sum);

  // -------------------------------------------------------------------------
  // Port-side outputs. These are combinational from gnt, req_* and wfull,
  // with no extra register stage.
  // -------------------------------------------------------------------------
  logic [CW-1:0] cnt_inc;
  logic          burst_done;

  assign busy       = (state_reg == GRANT);
  assign gnt        = gnt_reg;
  assign winc       = busy & own_valid & ~wfull;
  assign req_ready  = wfull ? '0 : gnt_reg;
  assign wdata      = data_or;
  assign cnt_inc    = cnt_reg + 1'b1;
  assign burst_done = (cnt_inc == BURST_W);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ptr_next   = ptr_reg;
    own_next   = own_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next = GRANT;
          gnt_next   = ONE_HOT0 << sel_idx;
          own_next   = sel_idx;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        // A full FIFO blocks winc. The counter and the grant then simply hold.
        if (winc) begin
          cnt_next = cnt_inc;
          if (own_last || burst_done) begin
            state_next = IDLE;
            gnt_next   = '0;
            ptr_next   = (own_reg == LAST_IDX) ? '0 : own_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ptr_reg   <= '0;
      own_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ptr_reg   <= ptr_next;
      own_reg   <= own_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
//
// Scoreboard bench for fifo_wr_arb (NREQ=4, DSIZE=8, BURST=4).
//
// Each requester is fed from a queue of words. The driver issues one cycle
// of stimulus at a time. For each cycle a transaction-level arbiter model
// (owner, pointer, word count) predicts the port outputs, and the driver
// pushes that prediction into exp_q. Predicted writes also go into word_q.
// A monitor, running on the falling edge, pops and compares those entries
// and logs every real write.
//
// Directed scenarios then check the write log against fixed expected
// sequences. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       gnt;
  logic                  busy;

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt       (gnt),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } word_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic       busy;
    logic       winc;
    logic [3:0] ready;
    logic [7:0] wdata;
  } exp_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } xfer_t;

  word_t rq [NREQ][$];     // pending words per requester
  exp_t  exp_q [$];        // per-cycle expected port outputs
  xfer_t word_q [$];       // expected writes, in order
  xfer_t log_q [$];        // observed writes

  int checks = 0;
  int errors = 0;

  // Reference arbiter state: owner (-1 = none), rotation pointer, words so far
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic add_word(input int r, input bit last, input logic [7:0] data);
    word_t w;
    w.last = last;
    w.data = data;
    rq[r].push_back(w);
  endtask

  // Drive one cycle and predict this cycle's outputs plus the next edge.
  task automatic step(input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic wf);
    exp_t  e;
    xfer_t x;
    int    g;
    int    i;
    @(posedge wclk);
    #1;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    wfull     = wf;
    e = '0;
    if (m_own < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (v[i]) begin
          m_own = i;
          m_cnt = 0;
          break;
        end
      end
    end else begin
      g       = m_own;
      e.gnt   = 4'b0001 << g;
      e.busy  = 1'b1;
      e.ready = wf ? 4'b0000 : e.gnt;
      e.winc  = v[g] && !wf;
      e.wdata = d[g*8 +: 8];
      if (e.winc) begin
        x.idx  = 2'(g);
        x.data = d[g*8 +: 8];
        word_q.push_back(x);
        void'(rq[g].pop_front());
        m_cnt++;
        if (l[g] || m_cnt == BURST) begin
          m_own = -1;
          m_ptr = (g + 1) % NREQ;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // vpct: chance (percent) that a requester with data is valid in a cycle.
  // fpct: chance that wfull is high. stall: requesters forced invalid.
  task automatic run(input int cycles, input int vpct, input int fpct,
                     input logic [3:0] stall);
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        wf;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() > 0) begin
          v[i]          = !stall[i] && ($urandom_range(99) < vpct);
          d[i*8 +: 8]   = rq[i][0].data;
          l[i]          = rq[i][0].last;
        end else begin
          v[i]          = 1'b0;
          d[i*8 +: 8]   = 8'($urandom);
          l[i]          = 1'($urandom);
        end
      end
      wf = ($urandom_range(99) < fpct);
      step(v, l, d, wf);
    end
  endtask

  task automatic do_reset(input bit check_now);
    @(posedge wclk);
    #3;
    wrst_n    = 1'b0;
    req_valid = '0;
    wfull     = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_gnt",   32'(gnt),       32'h0);
      chk("rst_winc",  32'(winc),      32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_wdata", 32'(wdata),     32'h0);
      chk("rst_busy",  32'(busy),      32'h0);
    end
    m_own = -1;
    m_ptr = 0;
    m_cnt = 0;
    word_q.delete();
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;
  endtask

  task automatic settle;
    @(negedge wclk);
    #1;
  endtask

  task automatic chk_log(input int n, input int idx, input int data);
    if (log_q.size() <= n) begin
      checks++;
      errors++;
      $display("FAIL log_%0d: missing, required src %0d data %0h", n, idx, data);
    end else begin
      chk($sformatf("log_%0d_src", n),  32'(log_q[n].idx),  32'(idx));
      chk($sformatf("log_%0d_data", n), 32'(log_q[n].data), 32'(data));
    end
  endtask

  // ---------------------------------------------------------------- monitor
  exp_t  mon_e;
  xfer_t mon_x;
  int    mon_idx;

  always @(negedge wclk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("gnt",       32'(gnt),       32'(mon_e.gnt));
      chk("busy",      32'(busy),      32'(mon_e.busy));
      chk("winc",      32'(winc),      32'(mon_e.winc));
      chk("req_ready", 32'(req_ready), 32'(mon_e.ready));
      chk("wdata",     32'(wdata),     32'(mon_e.wdata));
    end
    if (winc === 1'b1) begin
      mon_idx = 0;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) mon_idx = i;
      mon_x.idx  = 2'(mon_idx);
      mon_x.data = wdata;
      log_q.push_back(mon_x);
      $display("xfer t=%0t src=%0d data=%02h", $time, mon_idx, wdata);
      if (word_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got src %0d data %0h, required no write", mon_idx, wdata);
      end else begin
        mon_x = word_q.pop_front();
        chk("xfer_src",  32'(mon_idx), 32'(mon_x.idx));
        chk("xfer_data", 32'(wdata),   32'(mon_x.data));
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    repeat (2) @(posedge wclk);
    #2;
    chk("init_gnt",   32'(gnt),   32'h0);
    chk("init_busy",  32'(busy),  32'h0);
    chk("init_winc",  32'(winc),  32'h0);
    chk("init_wdata", 32'(wdata), 32'h0);
    wrst_n = 1'b1;

    // Single requester, then check that the pointer moved to 3
    add_word(2, 1'b0, 8'h11);
    add_word(2, 1'b1, 8'h22);
    log_q.delete();
    run(4, 100, 0, 4'b0000);
    settle();
    chk("single_count", 32'(log_q.size()), 32'd2);
    chk_log(0, 2, 8'h11);
    chk_log(1, 2, 8'h22);
    add_word(0, 1'b1, 8'hA0);
    add_word(3, 1'b1, 8'hD0);
    log_q.delete();
    run(6, 100, 0, 4'b0000);
    settle();
    chk_log(0, 3, 8'hD0);
    chk_log(1, 0, 8'hA0);

    // Round robin: every word is last
    do_reset(1'b0);
    for (int i = 0; i < NREQ; i++) begin
      add_word(i, 1'b1, 8'(8'h30 + i));
      add_word(i, 1'b1, 8'(8'h40 + i));
    end
    log_q.delete();
    run(12, 100, 0, 4'b0000);
    settle();
    chk_log(0, 0, 8'h30);
    chk_log(1, 1, 8'h31);
    chk_log(2, 2, 8'h32);
    chk_log(3, 3, 8'h33);
    chk_log(4, 0, 8'h40);

    // Burst cap: 6-word packet from requester 1 while requester 2 waits
    do_reset(1'b0);
    for (int j = 0; j < 6; j++) add_word(1, (j == 5), 8'(8'hA0 + j));
    add_word(2, 1'b1, 8'hB0);
    log_q.delete();
    run(14, 100, 0, 4'b0000);
    settle();
    chk("burst_count", 32'(log_q.size()), 32'd7);
    chk_log(0, 1, 8'hA0);
    chk_log(3, 1, 8'hA3);
    chk_log(4, 2, 8'hB0);
    chk_log(5, 1, 8'hA4);
    chk_log(6, 1, 8'hA5);

    // Full back-pressure for 3 cycles mid-grant
    do_reset(1'b0);
    for (int j = 0; j < 4; j++) add_word(0, (j == 3), 8'(8'hC0 + j));
    log_q.delete();
    run(3, 100, 0, 4'b0000);
    run(3, 100, 100, 4'b0000);
    run(5, 100, 0, 4'b0000);
    settle();
    chk("full_count", 32'(log_q.size()), 32'd4);
    chk_log(2, 0, 8'hC2);
    chk_log(3, 0, 8'hC3);

    // Owner stall while another requester is valid
    do_reset(1'b0);
    add_word(0, 1'b0, 8'hE0);
    add_word(0, 1'b0, 8'hE1);
    add_word(0, 1'b1, 8'hE2);
    add_word(1, 1'b1, 8'hF0);
    log_q.delete();
    run(2, 100, 0, 4'b0000);
    run(2, 100, 0, 4'b0001);
    run(6, 100, 0, 4'b0000);
    settle();
    chk_log(0, 0, 8'hE0);
    chk_log(1, 0, 8'hE1);
    chk_log(2, 0, 8'hE2);
    chk_log(3, 1, 8'hF0);

    // Reset in the middle of a packet
    do_reset(1'b0);
    for (int j = 0; j < 6; j++) add_word(1, 1'b0, 8'(8'h60 + j));
    run(3, 100, 0, 4'b0000);
    do_reset(1'b1);
    add_word(1, 1'b1, 8'h51);
    add_word(3, 1'b1, 8'h53);
    log_q.delete();
    run(6, 100, 0, 4'b0000);
    settle();
    chk_log(0, 1, 8'h51);
    chk_log(1, 3, 8'h53);

    // Randomized traffic: random packet lengths, owner stalls, wfull
    for (int r = 0; r < 3; r++) begin
      do_reset(1'b1);
      for (int i = 0; i < NREQ; i++) begin
        while (rq[i].size() < 30) begin
          int len;
          len = $urandom_range(7, 1);
          for (int j = 0; j < len; j++) add_word(i, (j == len - 1), 8'($urandom));
        end
      end
      run(300, 70, 25, 4'b0000);
    end

    settle();
    chk("exp_q_drained",  32'(exp_q.size()),  32'd0);
    chk("word_q_drained", 32'(word_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
